// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: parametrised inter-stage pipeline register with a
// two-entry skid buffer. It uses a valid/ready handshake with a registered
// in_ready. It supports flush, optional payload clearing on flush, and a
// saturating stall-cycle counter.
//
// Ports:
//   cpu_clk    - pipeline clock, rising edge
//   cpu_rst_n  - asynchronous active-low reset
//   in_valid   - upstream payload valid
//   in_ready   - stage can accept; driven straight from a flop
//   in_data    - upstream payload (DATA_W bits)
//   out_valid  - downstream payload valid
//   out_ready  - downstream consumes this cycle
//   out_data   - downstream payload (DATA_W bits)
//   flush      - kill all held entries at the next edge
//   cnt_clr    - synchronous clear of stall_cnt
//   stall_cnt  - saturating count of out_valid & ~out_ready cycles
//   occupancy  - number of held entries (0..2)
module pipe_skid_stage #(
  parameter int DATA_W       = 32,
  parameter bit CLR_ON_FLUSH = 1'b0,
  parameter int CNT_W        = 16
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [1:0]        occupancy
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic              main_v_r, skid_v_r, rdy_r;
  logic [DATA_W-1:0] main_d_r, skid_d_r;
  logic [CNT_W-1:0]  cnt_r;

  logic              main_v_s, skid_v_s;
  logic [DATA_W-1:0] main_d_s, skid_d_s;
  logic [CNT_W-1:0]  cnt_s;
  logic              acc_s, pop_s;

  // Handshake qualifiers.
  always_comb begin
    acc_s = in_valid & rdy_r;
    pop_s = main_v_r & out_ready;
  end

  // Next-state for the two storage entries.
  // Data registers take a new value only when their entry is written.
  always_comb begin
    main_v_s = main_v_r;
    skid_v_s = skid_v_r;
    main_d_s = main_d_r;
    skid_d_s = skid_d_r;
    if (flush) begin
      main_v_s = 1'b0;
      skid_v_s = 1'b0;
      if (CLR_ON_FLUSH) begin
        main_d_s = '0;
        skid_d_s = '0;
      end else begin
        main_d_s = main_d_r;
        skid_d_s = skid_d_r;
      end
    end else if (!main_v_r || pop_s) begin
      if (skid_v_r) begin
        // Skid drains into main; skid refills from the input when accepting.
        main_v_s = 1'b1;
        main_d_s = skid_d_r;
        skid_v_s = acc_s;
        if (acc_s) begin
          skid_d_s = in_data;
        end else begin
          skid_d_s = skid_d_r;
        end
      end else begin
        main_v_s = acc_s;
        if (acc_s) begin
          main_d_s = in_data;
        end else begin
          main_d_s = main_d_r;
        end
      end
    end else if (acc_s) begin
      // Main is blocked, so the accepted payload parks in skid.
      skid_v_s = 1'b1;
      skid_d_s = in_data;
    end else begin
      main_v_s = main_v_r;
      skid_v_s = skid_v_r;
    end
  end

  // Next value of the stall counter. Clear wins, and the count saturates.
  always_comb begin
    cnt_s = cnt_r;
    if (cnt_clr) begin
      cnt_s = {CNT_W{1'b0}};
    end else if (main_v_r && !out_ready && (cnt_r != CNT_MAX)) begin
      cnt_s = cnt_r + CNT_W'(1);
    end else begin
      cnt_s = cnt_r;
    end
  end

  // State registers. in_ready is held as the registered complement of the next skid_v.
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      main_v_r <= 1'b0;
      skid_v_r <= 1'b0;
      main_d_r <= '0;
      skid_d_r <= '0;
      rdy_r    <= 1'b1;
      cnt_r    <= {CNT_W{1'b0}};
    end else begin
      main_v_r <= main_v_s;
      skid_v_r <= skid_v_s;
      main_d_r <= main_d_s;
      skid_d_r <= skid_d_s;
      rdy_r    <= ~skid_v_s;
      cnt_r    <= cnt_s;
    end
  end

  assign in_ready  = rdy_r;
  assign out_valid = main_v_r;
  assign out_data  = main_d_r;
  assign stall_cnt = cnt_r;
  assign occupancy = {1'b0, main_v_r} + {1'b0, skid_v_r};

endmodule

// File: tb/tb_pipe_skid_stage.sv
module tb_pipe_skid_stage;

  localparam int DW = 70;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic          flush = 1'b0;
  logic          cnt_clr = 1'b0;
  logic [DW-1:0] in_data = '0;

  logic          a_in_ready, a_out_valid, b_in_ready, b_out_valid;
  logic [DW-1:0] a_out_data, b_out_data;
  logic [CW-1:0] a_stall, b_stall;
  logic [1:0]    a_occ, b_occ;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_skid_stage #(.DATA_W(DW), .CLR_ON_FLUSH(1'b0), .CNT_W(CW)) dut_a (
    .cpu_clk(clk), .cpu_rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_data(a_out_data), .flush(flush), .cnt_clr(cnt_clr),
    .stall_cnt(a_stall), .occupancy(a_occ));

  pipe_skid_stage #(.DATA_W(DW), .CLR_ON_FLUSH(1'b1), .CNT_W(CW)) dut_b (
    .cpu_clk(clk), .cpu_rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_data(b_out_data), .flush(flush), .cnt_clr(cnt_clr),
    .stall_cnt(b_stall), .occupancy(b_occ));

  // Advance one clock; outputs are sampled and inputs driven 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++;
    if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_out_data !== '0 ||
        a_occ !== 2'd0 || a_stall !== 4'd0) begin
      errors++;
      $display("FAIL reset: rdy=%b ov=%b od=%h occ=%0d st=%0d, want 1 0 0 0 0",
               a_in_ready, a_out_valid, a_out_data, a_occ, a_stall);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_stream();
    logic [DW-1:0] vals [3];
    vals[0] = 70'h11; vals[1] = 70'h22; vals[2] = 70'h33;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = vals[i];
      step();
      checks++;
      if (a_out_valid !== 1'b1 || a_out_data !== vals[i] || a_in_ready !== 1'b1 ||
          a_occ !== 2'd1 || a_stall !== 4'd0) begin
        errors++;
        $display("FAIL stream[%0d]: ov=%b od=%h rdy=%b occ=%0d st=%0d, want 1 %h 1 1 0",
                 i, a_out_valid, a_out_data, a_in_ready, a_occ, a_stall, vals[i]);
      end
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (a_out_valid !== 1'b0 || a_occ !== 2'd0) begin
      errors++;
      $display("FAIL stream_drain: ov=%b occ=%0d, want 0 0", a_out_valid, a_occ);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 70'h11;
    step();
    in_data = 70'h22;
    step();
    checks++;
    if (a_occ !== 2'd2 || a_in_ready !== 1'b0 || a_out_data !== 70'h11) begin
      errors++;
      $display("FAIL skid_fill: occ=%0d rdy=%b od=%h, want 2 0 11", a_occ, a_in_ready, a_out_data);
    end
    in_data = 70'h33;
    step();
    checks++;
    if (a_occ !== 2'd2 || a_in_ready !== 1'b0 || a_out_data !== 70'h11) begin
      errors++;
      $display("FAIL skid_hold: occ=%0d rdy=%b od=%h, want 2 0 11", a_occ, a_in_ready, a_out_data);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (a_out_data !== 70'h22 || a_occ !== 2'd1 || a_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL skid_drain1: od=%h occ=%0d rdy=%b, want 22 1 1", a_out_data, a_occ, a_in_ready);
    end
    step();
    checks++;
    if (a_out_data !== 70'h33 || a_out_valid !== 1'b1) begin
      errors++;
      $display("FAIL skid_drain2: od=%h ov=%b, want 33 1", a_out_data, a_out_valid);
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (a_out_valid !== 1'b0 || a_occ !== 2'd0) begin
      errors++;
      $display("FAIL skid_empty: ov=%b occ=%0d, want 0 0", a_out_valid, a_occ);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 70'hAA;
    step();
    in_data = 70'hBB;
    step();
    checks++;
    if (a_occ !== 2'd2 || b_occ !== 2'd2) begin
      errors++;
      $display("FAIL flush_pre: occ a=%0d b=%0d, want 2 2", a_occ, b_occ);
    end
    flush   = 1'b1;
    in_data = 70'hCC;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (a_out_valid !== 1'b0 || a_occ !== 2'd0 || a_in_ready !== 1'b1 || a_out_data !== 70'hAA) begin
      errors++;
      $display("FAIL flush_keep: ov=%b occ=%0d rdy=%b od=%h, want 0 0 1 aa",
               a_out_valid, a_occ, a_in_ready, a_out_data);
    end
    checks++;
    if (b_out_valid !== 1'b0 || b_occ !== 2'd0 || b_in_ready !== 1'b1 || b_out_data !== '0) begin
      errors++;
      $display("FAIL flush_clr: ov=%b occ=%0d rdy=%b od=%h, want 0 0 1 0",
               b_out_valid, b_occ, b_in_ready, b_out_data);
    end
    step();
    checks++;
    if (a_out_valid !== 1'b0 || a_occ !== 2'd0) begin
      errors++;
      $display("FAIL flush_after: ov=%b occ=%0d, want 0 0", a_out_valid, a_occ);
    end
  endtask

  task automatic test_stall_cnt();
    cnt_clr = 1'b1;
    step();
    cnt_clr   = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 70'h44;
    step();
    in_valid = 1'b0;
    checks++;
    if (a_stall !== 4'd0) begin
      errors++;
      $display("FAIL stall_start: got %0d want 0", a_stall);
    end
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 7 || i == 15 || i == 20) begin
        checks++;
        if (a_stall !== ((i > 15) ? 4'd15 : 4'(i))) begin
          errors++;
          $display("FAIL stall_count[%0d]: got %0d want %0d", i, a_stall, (i > 15) ? 15 : i);
        end
      end
    end
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    checks++;
    if (a_stall !== 4'd0) begin
      errors++;
      $display("FAIL stall_clr: got %0d want 0", a_stall);
    end
    step();
    step();
    checks++;
    if (a_stall !== 4'd2) begin
      errors++;
      $display("FAIL stall_resume: got %0d want 2", a_stall);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (a_out_valid !== 1'b0 || a_stall !== 4'd2) begin
      errors++;
      $display("FAIL stall_drain: ov=%b st=%0d, want 0 2", a_out_valid, a_stall);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 70'h61;
    step();
    in_data = 70'h62;
    step();
    in_valid = 1'b0;
    checks++;
    if (a_occ !== 2'd2 || a_stall === 4'd0) begin
      errors++;
      $display("FAIL arst_pre: occ=%0d st=%0d, want 2 nonzero", a_occ, a_stall);
    end
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_stall !== 4'd0 || a_occ !== 2'd0) begin
      errors++;
      $display("FAIL arst_now: ov=%b rdy=%b st=%0d occ=%0d, want 0 1 0 0",
               a_out_valid, a_in_ready, a_stall, a_occ);
    end
    step();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 70'h5A;
    step();
    in_valid = 1'b0;
    checks++;
    if (a_out_valid !== 1'b1 || a_out_data !== 70'h5A) begin
      errors++;
      $display("FAIL arst_resume: ov=%b od=%h, want 1 5a", a_out_valid, a_out_data);
    end
    step();
  endtask

  task automatic test_random();
    logic [DW-1:0] q [$];
    logic [DW-1:0] d;
    logic          rdy_before, exp_rdy, exp_ov, acc, pop;
    for (int c = 0; c < 10000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      d         = {$urandom, $urandom, $urandom};
      in_data   = d;
      out_ready = ($urandom_range(0, 2) != 0);
      // Toggle out_ready within the cycle: a registered in_ready must not move.
      rdy_before = a_in_ready;
      out_ready  = ~out_ready;
      #1;
      checks++;
      if (a_in_ready !== rdy_before) begin
        errors++;
        $display("FAIL rand_ready_comb[%0d]: got %b want %b", c, a_in_ready, rdy_before);
      end
      out_ready = ~out_ready;
      exp_rdy = (q.size() < 2);
      exp_ov  = (q.size() > 0);
      checks++;
      if (a_in_ready !== exp_rdy || a_out_valid !== exp_ov ||
          b_in_ready !== exp_rdy || b_out_valid !== exp_ov ||
          (exp_ov && (a_out_data !== q[0] || b_out_data !== q[0]))) begin
        errors++;
        $display("FAIL rand[%0d]: rdy=%b ov=%b od=%h want rdy=%b ov=%b od=%h",
                 c, a_in_ready, a_out_valid, a_out_data, exp_rdy, exp_ov,
                 exp_ov ? q[0] : '0);
      end
      acc = in_valid && exp_rdy;
      pop = exp_ov && out_ready;
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(d);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    step();
  endtask

  initial begin
    #1;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_stall_cnt();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
Parametrised successor to the fixed inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) of the rv32 pipeline. It carries an arbitrary-width payload bundle between two stages, using a valid/ready handshake with backpressure. A two-entry skid buffer provides full throughput with a registered in_ready. It adds flush (branch/exception kill), optional payload clearing, and a saturating stall-cycle counter for performance debugging.

Parameters:
DATA_W, 32, payload width in bits (pc4, inst, operands and control bits are concatenated upstream); legal range is 1 and above.
CLR_ON_FLUSH, 0, when 1 a flush also zeroes both payload registers; when 0 only the valid bits are cleared.
CNT_W, 16, width of the stall-cycle counter.

Ports:
cpu_clk  input  1  pipeline clock, rising edge.
cpu_rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  upstream stage presents a valid payload.
in_ready  output  1  this stage can accept a payload; driven directly from a flop.
in_data  input  DATA_W  upstream payload.
out_valid  output  1  downstream payload is valid (replaces the old valid_out).
out_ready  input  1  downstream stage consumes the payload this cycle.
out_data  output  DATA_W  payload to the downstream stage.
flush  input  1  kill all in-flight entries.
cnt_clr  input  1  synchronous clear of stall_cnt.
stall_cnt  output  CNT_W  count of cycles with out_valid=1 and out_ready=0, saturating.
occupancy  output  2  number of held entries: 0, 1 or 2.

Behaviour:
- Storage: main register (main_v, main_d) drives out_valid/out_data. Skid register (skid_v, skid_d) sits behind it.
- Reset (cpu_rst_n=0, asynchronous): main_v=0, skid_v=0, main_d=0, skid_d=0, stall_cnt=0. Resulting outputs: in_ready=1, out_valid=0, out_data=0, occupancy=0.
- in_ready is a registered equivalent of ~skid_v, with no combinational path from out_ready.
- acc = in_valid & in_ready. pop = out_valid & out_ready.
- Per-cycle update (no flush), by case:
  - main empty, or pop: main takes skid if skid_v (skid_v then becomes acc and skid takes in_data if acc); otherwise main takes in_data with main_v=acc.
  - main full, no pop, acc: skid takes in_data and skid_v=1.
  - main full, no pop, no acc: hold.
- Latency: in_data accepted at edge N appears on out_data after edge N when the stage is empty. Sustained throughput is 1 per cycle with out_ready held high.
- Ordering is strictly FIFO. Payloads are never duplicated or dropped, except by flush.
- flush=1 (highest priority after reset): next edge sets main_v=0 and skid_v=0. Any in_data offered in that cycle is discarded even though in_ready may be 1. A pop in that cycle still counts as consumed downstream. If CLR_ON_FLUSH=1, both data regs are also zeroed; otherwise data regs hold.
- Payload regs load only when their entry is being written (no toggling on bubbles).
- occupancy = main_v + skid_v. skid_v=1 implies main_v=1 (invariant).
- stall_cnt: increments at each edge where out_valid & ~out_ready. It saturates at 2^CNT_W-1 and does not wrap. cnt_clr=1 forces 0 and has priority over increment. It is unaffected by flush.
- Reset asserted mid-transfer immediately empties both entries. Payload in flight is lost by design.

Test Plan:
1. Reset, then in_valid=1 with in_data=0x11,0x22,0x33 on consecutive cycles and out_ready=1 -> out_data shows 0x11,0x22,0x33 one cycle later each; in_ready stays 1; occupancy=1; stall_cnt=0.
2. With main holding 0x11, hold out_ready=0 and offer 0x22 -> skid captures 0x22; in_ready falls to 0 next cycle; occupancy=2; 0x33 is held upstream. Then raise out_ready -> outputs 0x11, 0x22, 0x33 in order with no loss.
3. Occupancy 2 (0xAA main, 0xBB skid) and flush=1 with in_valid=1, in_data=0xCC -> next cycle out_valid=0, occupancy=0, in_ready=1; 0xCC is never output. With CLR_ON_FLUSH=1, out_data=0; with CLR_ON_FLUSH=0, out_data=0xAA.
4. CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt reaches 15 and holds. Assert cnt_clr during the stall -> 0 next cycle, then counting resumes.
5. Drop cpu_rst_n asynchronously between clock edges while occupancy=2 -> out_valid=0, in_ready=1, stall_cnt=0 immediately without waiting for a clock edge. After release, the stage accepts a new payload 0x5A with 1-cycle latency.
6. Random in_valid/out_ready stimulus, DATA_W=70, 10k cycles, scoreboard comparison -> exact in-order match; in_ready never depends combinationally on out_ready (checked by assertion).
